// File: rtl/mux_tree_pkg.sv
// Shared constants and sizing helpers for the pipelined radix-4 mux tree.
package mux_tree_pkg;

    localparam int RADIX      = 4;
    localparam int RADIX_LOG2 = 2;

    function automatic int n_in(input int levels);
        return RADIX ** levels;
    endfunction

    function automatic int sel_w(input int levels);
        return RADIX_LOG2 * levels;
    endfunction

endpackage

// File: rtl/mux_tree_pipe_mux4_stage.sv
// One registered radix-4 tree level: N_OUT muxes, a shared valid bit and the
// select bits later levels still need.
module mux4_stage
    import mux_tree_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int N_OUT     = 1,
    parameter int REM_SEL_W = 0,
    parameter int SEL_IN_W  = 2,
    parameter int SEL_LSB   = 0
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         adv,
    input  logic [N_OUT*RADIX*WIDTH-1:0]                 in_data,
    input  logic [SEL_IN_W-1:0]                          in_sel,
    input  logic                                         in_valid,
    output logic [N_OUT*WIDTH-1:0]                       out_data,
    output logic [((REM_SEL_W > 0) ? REM_SEL_W : 1)-1:0] out_sel,
    output logic                                         out_valid
);

    localparam int REG_SEL_W = (REM_SEL_W > 0) ? REM_SEL_W : 1;

    logic [RADIX_LOG2-1:0]  pick_s;
    logic [N_OUT*WIDTH-1:0] mux_s;
    logic [REG_SEL_W-1:0]   carry_s;
    logic [N_OUT*WIDTH-1:0] data_r;
    logic [REG_SEL_W-1:0]   sel_r;
    logic                   valid_r;

    assign pick_s = in_sel[SEL_LSB +: RADIX_LOG2];

    // The root level has nothing left to forward; drive a constant zero bit.
    if (REM_SEL_W > 0) begin : g_carry
        assign carry_s = in_sel[SEL_IN_W-1 -: REM_SEL_W];
    end else begin : g_no_carry
        assign carry_s = 1'b0;
    end

    // Radix-4 selection for every group of four lower-level outputs
    always_comb begin
        mux_s = '0;
        for (int j = 0; j < N_OUT; j++) begin
            case (pick_s)
                2'd0:    mux_s[j*WIDTH +: WIDTH] = in_data[(RADIX*j + 0)*WIDTH +: WIDTH];
                2'd1:    mux_s[j*WIDTH +: WIDTH] = in_data[(RADIX*j + 1)*WIDTH +: WIDTH];
                2'd2:    mux_s[j*WIDTH +: WIDTH] = in_data[(RADIX*j + 2)*WIDTH +: WIDTH];
                2'd3:    mux_s[j*WIDTH +: WIDTH] = in_data[(RADIX*j + 3)*WIDTH +: WIDTH];
                default: mux_s[j*WIDTH +: WIDTH] = {WIDTH{1'b0}};
            endcase
        end
    end

    // Level registers: valid follows every advance, payload loads only with a valid item
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= '0;
            sel_r   <= '0;
        end else if (adv) begin
            valid_r <= in_valid;
            if (in_valid) begin
                data_r <= mux_s;
                sel_r  <= carry_s;
            end
        end
    end

    assign out_data  = data_r;
    assign out_sel   = sel_r;
    assign out_valid = valid_r;

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N-to-1 radix-4 mux tree with valid/ready on both sides.
// Optional MUX_TREE_PIPE_SEL_ECHO_EN adds out_sel, the select that produced out_data.
module mux_tree_pipe
    import mux_tree_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int LEVELS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [n_in(LEVELS)*WIDTH-1:0] in_data,
    input  logic [sel_w(LEVELS)-1:0]      in_sel,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready
`ifdef MUX_TREE_PIPE_SEL_ECHO_EN
    ,
    output logic [sel_w(LEVELS)-1:0]      out_sel
`endif
);

    localparam int SEL_W = sel_w(LEVELS);
`ifdef MUX_TREE_PIPE_SEL_ECHO_EN
    localparam bit ECHO_EN = 1'b1;
`else
    localparam bit ECHO_EN = 1'b0;
`endif

    logic adv_s;

    // Whole pipeline moves together; a stalled full output freezes every level.
    assign adv_s    = out_ready | ~out_valid;
    assign in_ready = adv_s;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int N_OUT     = n_in(LEVELS - 1 - k);
        localparam int SEL_IN_W  = ECHO_EN ? SEL_W : SEL_W - RADIX_LOG2*k;
        localparam int REM_SEL_W = ECHO_EN ? SEL_W : SEL_W - RADIX_LOG2*(k + 1);
        localparam int SEL_LSB   = ECHO_EN ? RADIX_LOG2*k : 0;
        localparam int REG_SEL_W = (REM_SEL_W > 0) ? REM_SEL_W : 1;

        logic [N_OUT*RADIX*WIDTH-1:0] din_s;
        logic [SEL_IN_W-1:0]          sin_s;
        logic                         vin_s;
        logic [N_OUT*WIDTH-1:0]       dout_s;
        logic [REG_SEL_W-1:0]         sout_s;
        logic                         vout_s;

        if (k == 0) begin : g_head
            assign din_s = in_data;
            assign sin_s = in_sel;
            assign vin_s = in_valid;
        end else begin : g_tail
            assign din_s = g_lvl[k-1].dout_s;
            assign sin_s = g_lvl[k-1].sout_s;
            assign vin_s = g_lvl[k-1].vout_s;
        end

        mux4_stage #(
            .WIDTH     (WIDTH),
            .N_OUT     (N_OUT),
            .REM_SEL_W (REM_SEL_W),
            .SEL_IN_W  (SEL_IN_W),
            .SEL_LSB   (SEL_LSB)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .adv       (adv_s),
            .in_data   (din_s),
            .in_sel    (sin_s),
            .in_valid  (vin_s),
            .out_data  (dout_s),
            .out_sel   (sout_s),
            .out_valid (vout_s)
        );
    end

    assign out_data  = g_lvl[LEVELS-1].dout_s;
    assign out_valid = g_lvl[LEVELS-1].vout_s;

`ifdef MUX_TREE_PIPE_SEL_ECHO_EN
    assign out_sel = g_lvl[LEVELS-1].sout_s;
`else
    logic sel_unused_s;
    assign sel_unused_s = ^g_lvl[LEVELS-1].sout_s;
`endif

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Self-checking bench for mux_tree_pipe: table vectors, directed corner cases
// and random traffic against an item-level reference pipeline.
module tb_mux_tree_pipe;

    localparam int LV = 2;
    localparam int W  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [127:0] in_data;
    logic [3:0]   in_sel;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [7:0]   out_data;

    logic [63:0]  in_data3;
    logic [5:0]   in_sel3;
    logic         in_valid3, in_ready3, out_valid3, out_ready3;
    logic         out_data3;

`ifdef MUX_TREE_PIPE_SEL_ECHO_EN
    logic [3:0]   out_sel;
    logic [5:0]   out_sel3;
`endif

    mux_tree_pipe #(.WIDTH(W), .LEVELS(LV)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_TREE_PIPE_SEL_ECHO_EN
        , .out_sel(out_sel)
`endif
    );

    mux_tree_pipe #(.WIDTH(1), .LEVELS(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_sel(in_sel3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready3)
`ifdef MUX_TREE_PIPE_SEL_ECHO_EN
        , .out_sel(out_sel3)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference: LV item slots, each holding the channel value picked at acceptance.
    logic       mv[LV];
    logic [7:0] md[LV];
    logic [3:0] ms[LV];

    typedef struct {
        logic       v;
        logic [3:0] s;
        logic       r;
        logic       eov;
        logic [7:0] eod;
        logic       eir;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < LV; i++) begin
            mv[i] = 1'b0;
            md[i] = 8'h00;
            ms[i] = 4'h0;
        end
    endtask

    task automatic set_channels();
        for (int i = 0; i < 16; i++) in_data[i*W +: W] = 8'hA0 + 8'(i);
    endtask

    // One clock: check outputs mid-cycle, advance the model, then return after the edge.
    task automatic step(input int ti);
        logic adv;
        @(negedge clk);
        adv = out_ready | ~mv[LV-1];
        chk("in_ready", 32'(in_ready), 32'(adv));
        chk("out_valid", 32'(out_valid), 32'(mv[LV-1]));
        if (mv[LV-1]) begin
            chk("out_data", 32'(out_data), 32'(md[LV-1]));
`ifdef MUX_TREE_PIPE_SEL_ECHO_EN
            chk("out_sel", 32'(out_sel), 32'(ms[LV-1]));
`endif
        end
        if (ti >= 0) begin
            chk("tbl_out_valid", 32'(out_valid), 32'(tbl[ti].eov));
            chk("tbl_in_ready", 32'(in_ready), 32'(tbl[ti].eir));
            if (tbl[ti].eov) chk("tbl_out_data", 32'(out_data), 32'(tbl[ti].eod));
        end
        if (rst) begin
            clear_model();
        end else if (adv) begin
            for (int i = LV - 1; i > 0; i--) begin
                mv[i] = mv[i-1];
                md[i] = md[i-1];
                ms[i] = ms[i-1];
            end
            mv[0] = in_valid;
            md[0] = in_data[32'(in_sel)*W +: W];
            ms[0] = in_sel;
        end
        @(posedge clk);
        #1;
    endtask

    logic       exp3_v[6];
    logic       exp3_d[6];

    initial begin
        // bubble 1,0,1 then a stream 3,7,12 stalled for three cycles
        tbl[0]  = '{1'b1, 4'd1,  1'b1, 1'b0, 8'h00, 1'b1};
        tbl[1]  = '{1'b0, 4'd0,  1'b1, 1'b0, 8'h00, 1'b1};
        tbl[2]  = '{1'b1, 4'd3,  1'b1, 1'b1, 8'hA1, 1'b1};
        tbl[3]  = '{1'b0, 4'd0,  1'b1, 1'b0, 8'h00, 1'b1};
        tbl[4]  = '{1'b0, 4'd0,  1'b1, 1'b1, 8'hA3, 1'b1};
        tbl[5]  = '{1'b0, 4'd0,  1'b1, 1'b0, 8'h00, 1'b1};
        tbl[6]  = '{1'b1, 4'd3,  1'b1, 1'b0, 8'h00, 1'b1};
        tbl[7]  = '{1'b1, 4'd7,  1'b1, 1'b0, 8'h00, 1'b1};
        tbl[8]  = '{1'b1, 4'd12, 1'b0, 1'b1, 8'hA3, 1'b0};
        tbl[9]  = '{1'b1, 4'd12, 1'b0, 1'b1, 8'hA3, 1'b0};
        tbl[10] = '{1'b1, 4'd12, 1'b0, 1'b1, 8'hA3, 1'b0};
        tbl[11] = '{1'b1, 4'd12, 1'b1, 1'b1, 8'hA3, 1'b1};
        tbl[12] = '{1'b0, 4'd0,  1'b1, 1'b1, 8'hA7, 1'b1};
        tbl[13] = '{1'b0, 4'd0,  1'b1, 1'b1, 8'hAC, 1'b1};
        tbl[14] = '{1'b0, 4'd0,  1'b1, 1'b0, 8'h00, 1'b1};

        rst = 1'b1;
        in_data = '0; in_sel = 4'd0; in_valid = 1'b0; out_ready = 1'b1;
        in_data3 = '0; in_sel3 = 6'd0; in_valid3 = 1'b0; out_ready3 = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("init_out_data", 32'(out_data), 32'h0);
`ifdef MUX_TREE_PIPE_SEL_ECHO_EN
        chk("init_out_sel", 32'(out_sel), 32'h0);
`endif
        step(-1);

        set_channels();
        for (int i = 0; i < 15; i++) begin
            in_valid  = tbl[i].v;
            in_sel    = tbl[i].s;
            out_ready = tbl[i].r;
            step(i);
        end

        // back-to-back select sweep at full rate
        out_ready = 1'b1;
        for (int s = 0; s < 16; s++) begin
            in_valid = 1'b1;
            in_sel   = 4'(s);
            step(-1);
        end
        in_valid = 1'b0;
        repeat (3) step(-1);

        // random traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            in_sel    = 4'($urandom_range(0, 15));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            step(-1);
        end

        // reset with two items in flight
        set_channels();
        out_ready = 1'b1;
        in_valid = 1'b1; in_sel = 4'd5; step(-1);
        in_valid = 1'b1; in_sel = 4'd6; step(-1);
        out_ready = 1'b0;
        rst = 1'b1;
        clear_model();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) step(-1);

        // three-level tree: only channel 63 carries a one
        exp3_v = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        exp3_d = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        in_data3 = 64'h8000_0000_0000_0000;
        for (int c = 0; c < 6; c++) begin
            in_valid3 = (c < 2);
            in_sel3   = (c == 0) ? 6'd63 : 6'd62;
            @(negedge clk);
            chk("l3_in_ready", 32'(in_ready3), 32'h1);
            chk("l3_out_valid", 32'(out_valid3), 32'(exp3_v[c]));
            if (exp3_v[c]) begin
                chk("l3_out_data", 32'(out_data3), 32'(exp3_d[c]));
`ifdef MUX_TREE_PIPE_SEL_ECHO_EN
                chk("l3_out_sel", 32'(out_sel3), (c == 3) ? 32'd63 : 32'd62);
`endif
            end
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_tree_pipe.md
# mux_tree_pipe

Parametrised, pipelined N-to-1 multiplexer built as a radix-4 tree with one register stage per tree level and a valid/ready handshake on both sides. It generalises the combinational 16:1 tree (four 4:1 leaves plus one 4:1 root) to arbitrary data width and depth, and adds backpressure. It sits between wide multi-source datapaths and single-consumer sinks where combinational depth of a flat mux breaks timing.

## Interface
Parameters:
- WIDTH, 1, bits per input channel
- LEVELS, 2, tree depth; N_IN = 4**LEVELS inputs (default 16); SEL_W = 2*LEVELS

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  N_IN*WIDTH  flattened channels; channel i at [i*WIDTH +: WIDTH]
- in_sel  input  SEL_W  channel select
- in_valid  input  1  in_data/in_sel valid
- in_ready  output  1  tree accepts this cycle
- out_data  output  WIDTH  selected channel
- out_valid  output  1  out_data valid
- out_ready  input  1  sink accepts

## Operation
- Tree level k (0 = leaves) has 4**(LEVELS-1-k) radix-4 muxes; level k selects with sel[2k+1:2k] (low bits at leaves, matching the existing 16:1 arrangement). Group j at level k takes level k-1 outputs 4j..4j+3.
- Every level registers its mux outputs, a valid bit, and the unconsumed select bits sel[SEL_W-1:2k+2].
- Global advance: adv = out_ready | ~out_valid. When adv=1, all levels shift one step; level 0 captures in_valid and in_data/in_sel. When adv=0, all levels hold.
- in_ready = adv (combinational from out_ready and the output valid register). Transfer in = in_valid & in_ready; out = out_valid & out_ready.
- Bubbles are not collapsed: an empty middle stage stays in place while the output is stalled.
- The data register at each level loads only when adv=1 and the incoming valid is 1; valid registers load on every adv.
- out_data/out_valid are the root-level registers.
- Reset: all valid bits 0, all data and select registers 0; out_valid=0, out_data=0, in_ready=1 from the first cycle after reset release.
- Reset asserted mid-operation discards all in-flight items immediately; no output handshake completes for them.

## Timing
- Latency: LEVELS cycles from input transfer to out_valid when out_ready=1 (default 2).
- Throughput: one item per cycle with out_ready held high.
- Stall: out_ready low with out_valid high freezes the whole pipeline the same cycle and deasserts in_ready combinationally. out_data stable while out_valid & ~out_ready.
- Simultaneous output accept and input accept in the same cycle is legal and required at full rate.
- No combinational path from in_data/in_sel to outputs; one gate-level path from out_ready to in_ready.

## Configuration
- MUX_TREE_PIPE_SEL_ECHO_EN defined: extra output port out_sel (SEL_W) carrying the full in_sel that produced the current out_data; every level carries the full select instead of only the remaining bits; out_sel reset value 0.
- Not defined: no out_sel port; levels carry only unconsumed select bits.

## Structure
- Package mux_tree_pkg: constant RADIX=4, RADIX_LOG2=2, and functions n_in(levels) and sel_w(levels).
- One sub-module mux4_stage: registered radix-4 level, parameters WIDTH, N_OUT, REM_SEL_W; generate loop instantiates LEVELS of them.

## Test plan
- Reset: assert rst mid-stream with 2 items in flight -> out_valid=0, out_data=0, in_ready=1 next cycle; no stale item emerges after release.
- Select sweep (WIDTH=8, LEVELS=2): in_data channel i = 8'hA0+i, in_sel 0..15 back-to-back, out_ready=1 -> out_data 8'hA0..8'hAF, each 2 cycles after input, one per cycle.
- Backpressure: stream sel=3,7,12 with out_ready low on cycles 3-5 -> out_data held at channel 3 value, in_ready=0 during stall, no loss or duplication, order preserved.
- Bubble: in_valid pattern 1,0,1 with out_ready=1 -> out_valid pattern 1,0,1 delayed by LEVELS.
- Depth scaling: LEVELS=3 (64 inputs), sel=6'd63 with channel 63 = 1, others 0 -> out_data=1 after 3 cycles; sel=6'd62 -> 0.
- With MUX_TREE_PIPE_SEL_ECHO_EN: sel=4'd9 -> out_sel=9 coincident with out_valid; without macro, build has no out_sel port.
